// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core (F/D/X/M/W).
// Tracks the destination register of the instructions in X, M and W. From
// those records it produces load-use stalls, X-stage forwarding selects,
// W-to-D bypass flags, branch flushes, and stall/flush performance counters.
module hazard_ctrl #(
  parameter int unsigned FORWARD_EN = 1,
  parameter int unsigned COUNT_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               d_valid,
  input  logic [4:0]         d_rs1,
  input  logic [4:0]         d_rs2,
  input  logic               d_use_rs1,
  input  logic               d_use_rs2,
  input  logic [4:0]         d_rd,
  input  logic               d_regwe,
  input  logic               d_is_load,
  input  logic               x_br_taken,
  output logic               stall,
  output logic               flush_d,
  output logic               bubble_x,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b,
  output logic               byp_d_rs1,
  output logic               byp_d_rs2,
  output logic [COUNT_W-1:0] stall_cnt,
  output logic [COUNT_W-1:0] flush_cnt
);

  // In-flight instruction records
  logic       x_valid, x_regwe, x_is_load, x_use_rs1, x_use_rs2;
  logic [4:0] x_rd, x_rs1, x_rs2;
  logic       m_valid, m_regwe, m_is_load;
  logic [4:0] m_rd;
  logic       w_valid, w_regwe;
  logic [4:0] w_rd;

  // A record writes register r only if it is valid, writes, and r is not x0
  function automatic logic writes(input logic v, input logic we,
                                  input logic [4:0] rd, input logic [4:0] r);
    return v & we & (rd == r) & (r != 5'd0);
  endfunction

  logic d_src1_x, d_src2_x, d_src1_m, d_src2_m;
  logic raw_stall;

  // Stall request: load-use only with forwarding, any X/M RAW without it
  always_comb begin
    d_src1_x  = d_valid & d_use_rs1 & writes(x_valid, x_regwe, x_rd, d_rs1);
    d_src2_x  = d_valid & d_use_rs2 & writes(x_valid, x_regwe, x_rd, d_rs2);
    d_src1_m  = d_valid & d_use_rs1 & writes(m_valid, m_regwe, m_rd, d_rs1);
    d_src2_m  = d_valid & d_use_rs2 & writes(m_valid, m_regwe, m_rd, d_rs2);
    raw_stall = 1'b0;
    if (FORWARD_EN != 0)
      raw_stall = x_is_load & (d_src1_x | d_src2_x);
    else
      raw_stall = d_src1_x | d_src2_x | d_src1_m | d_src2_m;
  end

  // Taken branch overrides the stall: the stalled D instruction is flushed anyway
  always_comb begin
    stall    = raw_stall & ~x_br_taken;
    flush_d  = x_br_taken;
    bubble_x = stall | x_br_taken;
  end

  // Operand forwarding for X; the youngest producer (M) wins over W
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (FORWARD_EN != 0 && x_valid) begin
      if (x_use_rs1 && writes(m_valid, m_regwe, m_rd, x_rs1) && !m_is_load)
        fwd_a = 2'b01;
      else if (x_use_rs1 && writes(w_valid, w_regwe, w_rd, x_rs1))
        fwd_a = 2'b10;
      if (x_use_rs2 && writes(m_valid, m_regwe, m_rd, x_rs2) && !m_is_load)
        fwd_b = 2'b01;
      else if (x_use_rs2 && writes(w_valid, w_regwe, w_rd, x_rs2))
        fwd_b = 2'b10;
    end
  end

  // D reads a register that W writes back at the same edge
  always_comb begin
    byp_d_rs1 = d_valid & d_use_rs1 & writes(w_valid, w_regwe, w_rd, d_rs1);
    byp_d_rs2 = d_valid & d_use_rs2 & writes(w_valid, w_regwe, w_rd, d_rs2);
  end

  // Advance the X -> M -> W record pipeline; X takes D or a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      x_valid   <= 1'b0;
      x_regwe   <= 1'b0;
      x_is_load <= 1'b0;
      x_use_rs1 <= 1'b0;
      x_use_rs2 <= 1'b0;
      x_rd      <= '0;
      x_rs1     <= '0;
      x_rs2     <= '0;
      m_valid   <= 1'b0;
      m_regwe   <= 1'b0;
      m_is_load <= 1'b0;
      m_rd      <= '0;
      w_valid   <= 1'b0;
      w_regwe   <= 1'b0;
      w_rd      <= '0;
    end else begin
      w_valid   <= m_valid;
      w_regwe   <= m_regwe;
      w_rd      <= m_rd;
      m_valid   <= x_valid;
      m_regwe   <= x_regwe;
      m_is_load <= x_is_load;
      m_rd      <= x_rd;
      if (bubble_x || !d_valid) begin
        x_valid   <= 1'b0;
        x_regwe   <= 1'b0;
        x_is_load <= 1'b0;
        x_use_rs1 <= 1'b0;
        x_use_rs2 <= 1'b0;
        x_rd      <= '0;
        x_rs1     <= '0;
        x_rs2     <= '0;
      end else begin
        x_valid   <= 1'b1;
        x_regwe   <= d_regwe;
        x_is_load <= d_is_load;
        x_use_rs1 <= d_use_rs1;
        x_use_rs2 <= d_use_rs2;
        x_rd      <= d_rd;
        x_rs1     <= d_rs1;
        x_rs2     <= d_rs2;
      end
    end
  end

  // Performance counters, wrapping modulo 2^COUNT_W
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall)   stall_cnt <= stall_cnt + COUNT_W'(1);
      if (flush_d) flush_cnt <= flush_cnt + COUNT_W'(1);
    end
  end

endmodule
